// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave); one request outstanding at a time.
interface fetch_unit_if #(
  parameter int WIDTH = 32
);
  logic             req;
  logic [WIDTH-1:0] addr;
  logic             rvalid;
  logic [WIDTH-1:0] rdata;

  modport master (output req, output addr, input rvalid, input rdata);
  modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests,
// applies EX redirects and drops stale responses. FETCH_PERF_CNT_EN adds a wait-cycle counter.
module fetch_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_if,
  input  logic              redirect_valid,
  input  logic [WIDTH-1:0]  redirect_pc,
  fetch_unit_if.master      imem,
  output logic [WIDTH-1:0]  instr_if,
  output logic [WIDTH-1:0]  pc_if,
  output logic [WIDTH-1:0]  pc_plus4_if,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       fetch_wait_cycles,
`endif
  output logic              fetch_valid
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(32'd4);

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] pc_r, pc_nxt_s, pc_plus4_s;
  logic [WIDTH-1:0] ibuf_r;
  logic             ibuf_ld_s;
  logic             req_s;
  logic [WIDTH-1:0] addr_s;
  logic             valid_s;

  assign pc_plus4_s = pc_r + PC_STEP;

  // State, PC and instruction buffer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_FETCH;
      pc_r    <= RESET_PC;
      ibuf_r  <= NOP_INSTR;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      if (ibuf_ld_s) begin
        ibuf_r <= imem.rdata;
      end else begin
        ibuf_r <= ibuf_r;
      end
    end
  end

  // Next-state, request and output qualifier logic; redirect overrides everything
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    ibuf_ld_s   = 1'b0;
    req_s       = 1'b0;
    addr_s      = pc_r;
    valid_s     = 1'b0;
    if (redirect_valid) begin
      pc_nxt_s = redirect_pc;
      case (state_r)
        // A response arriving with the redirect retires the stale request
        ST_WAIT:  state_nxt_s = imem.rvalid ? ST_FETCH : ST_DROP;
        ST_DROP:  state_nxt_s = imem.rvalid ? ST_FETCH : ST_DROP;
        ST_FETCH: state_nxt_s = ST_FETCH;
        ST_VALID: state_nxt_s = ST_FETCH;
        default:  state_nxt_s = ST_FETCH;
      endcase
    end else begin
      case (state_r)
        ST_FETCH: begin
          req_s       = 1'b1;
          state_nxt_s = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem.rvalid) begin
            ibuf_ld_s   = 1'b1;
            state_nxt_s = ST_VALID;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_VALID: begin
          valid_s = 1'b1;
          if (stall_if) begin
            state_nxt_s = ST_VALID;
          end else begin
            req_s       = 1'b1;
            addr_s      = pc_plus4_s;
            pc_nxt_s    = pc_plus4_s;
            state_nxt_s = ST_WAIT;
          end
        end
        ST_DROP: begin
          if (imem.rvalid) begin
            state_nxt_s = ST_FETCH;
          end else begin
            state_nxt_s = ST_DROP;
          end
        end
        default: state_nxt_s = ST_FETCH;
      endcase
    end
  end

  assign imem.req    = req_s & ~rst;
  assign imem.addr   = addr_s;
  assign fetch_valid = valid_s;
  assign instr_if    = valid_s ? ibuf_r : NOP_INSTR;
  assign pc_if       = pc_r;
  assign pc_plus4_if = pc_plus4_s;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] wait_cnt_r;

  // Saturating count of cycles spent waiting on or draining imem responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= 32'd0;
    end else if (((state_r == ST_WAIT) || (state_r == ST_DROP)) && (wait_cnt_r != 32'hFFFF_FFFF)) begin
      wait_cnt_r <= wait_cnt_r + 32'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign fetch_wait_cycles = wait_cnt_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a behavioural instruction memory
// of programmable latency.
module tb_fetch_unit;
  logic        clk;
  logic        rst;
  logic        stall_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr_if;
  logic [31:0] pc_if;
  logic [31:0] pc_plus4_if;
  logic        fetch_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_wait_cycles;
`endif

  fetch_unit_if #(.WIDTH(32)) imem ();

  fetch_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .stall_if(stall_if),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem(imem),
    .instr_if(instr_if),
    .pc_if(pc_if),
    .pc_plus4_if(pc_plus4_if),
`ifdef FETCH_PERF_CNT_EN
    .fetch_wait_cycles(fetch_wait_cycles),
`endif
    .fetch_valid(fetch_valid)
  );

  localparam logic [31:0] NOP = 32'h0000_0013;

  int          total;
  int          bad;
  int          lat;
  int          cnt;
  int          overlap;
  logic [31:0] addr_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'd0) ? 32'h0010_0093 : (a ^ 32'h5A5A_0000);
  endfunction

  // One clock cycle: drive inputs and memory response just after the edge,
  // then capture any request at the falling edge where outputs are checked.
  task automatic cycle(input logic r, input logic s, input logic rv, input logic [31:0] rp);
    @(posedge clk);
    #1;
    rst            = r;
    stall_if       = s;
    redirect_valid = rv;
    redirect_pc    = rp;
    imem.rvalid    = 1'b0;
    if (r) begin
      cnt = 0;
    end else if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        imem.rvalid = 1'b1;
        imem.rdata  = mem_word(addr_q);
      end
    end
    @(negedge clk);
    if (!r && imem.req) begin
      if (cnt != 0) overlap = overlap + 1;
      cnt    = lat;
      addr_q = imem.addr;
    end
  endtask

  task automatic do_reset();
    overlap = 0;
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_reset();
    lat = 1;
    do_reset();
    total++; if (imem.req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem.req); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", fetch_valid); end
    total++; if (instr_if !== NOP) begin bad++; $display("FAIL rst_instr: got %h want %h", instr_if, NOP); end
    total++; if (pc_if !== 32'd0) begin bad++; $display("FAIL rst_pc: got %h want 0", pc_if); end
    total++; if (pc_plus4_if !== 32'd4) begin bad++; $display("FAIL rst_pc4: got %h want 4", pc_plus4_if); end
`ifdef FETCH_PERF_CNT_EN
    total++; if (fetch_wait_cycles !== 32'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", fetch_wait_cycles); end
`endif
  endtask

  task automatic test_first_fetch();
    lat = 1;
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    total++; if (imem.req !== 1'b1 || imem.addr !== 32'd0) begin bad++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0", imem.req, imem.addr); end
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    total++; if (imem.req !== 1'b0 || fetch_valid !== 1'b0) begin bad++; $display("FAIL first_wait: got req=%b valid=%b want 0 0", imem.req, fetch_valid); end
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    total++; if (fetch_valid !== 1'b1 || instr_if !== 32'h0010_0093) begin bad++; $display("FAIL first_instr: got valid=%b instr=%h want 1 00100093", fetch_valid, instr_if); end
    total++; if (pc_if !== 32'd0 || pc_plus4_if !== 32'd4) begin bad++; $display("FAIL first_pc: got %h/%h want 0/4", pc_if, pc_plus4_if); end
    total++; if (imem.req !== 1'b1 || imem.addr !== 32'd4) begin bad++; $display("FAIL first_next_req: got req=%b addr=%h want 1 4", imem.req, imem.addr); end
  endtask

  task automatic test_sustained();
    int n;
    lat = 3;
    do_reset();
    n = 0;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'd0);
      if (fetch_valid === 1'b1) begin
        total++; if (c !== 5 + 4 * n) begin bad++; $display("FAIL sus_timing: got cycle %0d want %0d", c, 5 + 4 * n); end
        total++; if (pc_if !== 32'(4 * n)) begin bad++; $display("FAIL sus_pc: got %h want %h", pc_if, 32'(4 * n)); end
        total++; if (instr_if !== mem_word(32'(4 * n))) begin bad++; $display("FAIL sus_instr: got %h want %h", instr_if, mem_word(32'(4 * n))); end
        n++;
      end
    end
    total++; if (n !== 4) begin bad++; $display("FAIL sus_count: got %0d want 4", n); end
    total++; if (overlap !== 0) begin bad++; $display("FAIL sus_overlap: got %0d want 0", overlap); end
  endtask

  task automatic test_stall();
    lat = 1;
    do_reset();
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      total++; if (fetch_valid !== 1'b1 || pc_if !== 32'd8 || pc_plus4_if !== 32'd12) begin bad++; $display("FAIL stall_hold: got valid=%b pc=%h pc4=%h want 1 8 c", fetch_valid, pc_if, pc_plus4_if); end
      total++; if (instr_if !== 32'h5A5A_0008 || imem.req !== 1'b0) begin bad++; $display("FAIL stall_instr: got instr=%h req=%b want 5a5a0008 0", instr_if, imem.req); end
    end
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    total++; if (imem.req !== 1'b1 || imem.addr !== 32'd12) begin bad++; $display("FAIL stall_release: got req=%b addr=%h want 1 c", imem.req, imem.addr); end
  endtask

  task automatic test_redirect();
    int stray;
    lat = 3;
    do_reset();
    repeat (5) cycle(1'b0, 1'b0, 1'b0, 32'd0);
    total++; if (fetch_valid !== 1'b1 || imem.addr !== 32'd4) begin bad++; $display("FAIL redir_pre: got valid=%b addr=%h want 1 4", fetch_valid, imem.addr); end
    cycle(1'b0, 1'b0, 1'b1, 32'h100);
    total++; if (fetch_valid !== 1'b0 || imem.req !== 1'b0) begin bad++; $display("FAIL redir_cycle: got valid=%b req=%b want 0 0", fetch_valid, imem.req); end
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    total++; if (pc_if !== 32'h100 || imem.req !== 1'b0) begin bad++; $display("FAIL redir_drop: got pc=%h req=%b want 100 0", pc_if, imem.req); end
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    total++; if (fetch_valid !== 1'b0 || instr_if !== NOP) begin bad++; $display("FAIL redir_stale: got valid=%b instr=%h want 0 %h", fetch_valid, instr_if, NOP); end
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    total++; if (imem.req !== 1'b1 || imem.addr !== 32'h100) begin bad++; $display("FAIL redir_req: got req=%b addr=%h want 1 100", imem.req, imem.addr); end
    stray = 0;
    repeat (3) begin
      cycle(1'b0, 1'b0, 1'b0, 32'd0);
      if (fetch_valid !== 1'b0) stray++;
    end
    total++; if (stray !== 0) begin bad++; $display("FAIL redir_bubble: got %0d valid cycles want 0", stray); end
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    total++; if (fetch_valid !== 1'b1 || pc_if !== 32'h100 || pc_plus4_if !== 32'h104) begin bad++; $display("FAIL redir_target: got valid=%b pc=%h pc4=%h want 1 100 104", fetch_valid, pc_if, pc_plus4_if); end
    total++; if (instr_if !== 32'h5A5A_0100) begin bad++; $display("FAIL redir_instr: got %h want 5a5a0100", instr_if); end
`ifdef FETCH_PERF_CNT_EN
    total++; if (fetch_wait_cycles !== 32'd9) begin bad++; $display("FAIL perf_cnt: got %0d want 9", fetch_wait_cycles); end
`endif
  endtask

  task automatic test_double_redirect();
    int stray;
    lat = 3;
    do_reset();
    stray = 0;
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 32'h200);
    if (fetch_valid !== 1'b0) stray++;
    total++; if (imem.req !== 1'b0) begin bad++; $display("FAIL dbl_r1_req: got %b want 0", imem.req); end
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    if (fetch_valid !== 1'b0) stray++;
    total++; if (imem.req !== 1'b1 || imem.addr !== 32'h200) begin bad++; $display("FAIL dbl_req1: got req=%b addr=%h want 1 200", imem.req, imem.addr); end
    cycle(1'b0, 1'b0, 1'b1, 32'h300);
    if (fetch_valid !== 1'b0) stray++;
    cycle(1'b0, 1'b0, 1'b1, 32'h400);
    if (fetch_valid !== 1'b0) stray++;
    total++; if (imem.req !== 1'b0 || pc_if !== 32'h300) begin bad++; $display("FAIL dbl_drop: got req=%b pc=%h want 0 300", imem.req, pc_if); end
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    if (fetch_valid !== 1'b0) stray++;
    total++; if (imem.req !== 1'b0) begin bad++; $display("FAIL dbl_drain: got req=%b want 0", imem.req); end
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    total++; if (imem.req !== 1'b1 || imem.addr !== 32'h400) begin bad++; $display("FAIL dbl_req2: got req=%b addr=%h want 1 400", imem.req, imem.addr); end
    repeat (3) begin
      cycle(1'b0, 1'b0, 1'b0, 32'd0);
      if (fetch_valid !== 1'b0) stray++;
    end
    total++; if (stray !== 0) begin bad++; $display("FAIL dbl_bubble: got %0d valid cycles want 0", stray); end
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    total++; if (fetch_valid !== 1'b1 || pc_if !== 32'h400 || instr_if !== 32'h5A5A_0400) begin bad++; $display("FAIL dbl_target: got valid=%b pc=%h instr=%h want 1 400 5a5a0400", fetch_valid, pc_if, instr_if); end
    total++; if (overlap !== 0) begin bad++; $display("FAIL dbl_overlap: got %0d want 0", overlap); end
  endtask

  task automatic test_wrap();
    lat = 1;
    do_reset();
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    total++; if (imem.req !== 1'b0) begin bad++; $display("FAIL wrap_redir_req: got %b want 0", imem.req); end
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    total++; if (imem.req !== 1'b1 || imem.addr !== 32'hFFFF_FFFC || pc_plus4_if !== 32'd0) begin bad++; $display("FAIL wrap_req: got req=%b addr=%h pc4=%h want 1 fffffffc 0", imem.req, imem.addr, pc_plus4_if); end
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    total++; if (fetch_valid !== 1'b1 || pc_if !== 32'hFFFF_FFFC || instr_if !== 32'hA5A5_FFFC) begin bad++; $display("FAIL wrap_valid: got valid=%b pc=%h instr=%h want 1 fffffffc a5a5fffc", fetch_valid, pc_if, instr_if); end
    total++; if (imem.req !== 1'b1 || imem.addr !== 32'd0) begin bad++; $display("FAIL wrap_next: got req=%b addr=%h want 1 0", imem.req, imem.addr); end
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    total++; if (pc_if !== 32'd0 || pc_plus4_if !== 32'd4) begin bad++; $display("FAIL wrap_pc: got %h/%h want 0/4", pc_if, pc_plus4_if); end
  endtask

  task automatic test_reset_mid();
    lat = 3;
    do_reset();
    cycle(1'b0, 1'b0, 1'b1, 32'h80);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    total++; if (imem.req !== 1'b1 || imem.addr !== 32'h80) begin bad++; $display("FAIL mid_req: got req=%b addr=%h want 1 80", imem.req, imem.addr); end
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    total++; if (pc_if !== 32'h80) begin bad++; $display("FAIL mid_wait_pc: got %h want 80", pc_if); end
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    total++; if (imem.req !== 1'b0 || fetch_valid !== 1'b0 || instr_if !== NOP) begin bad++; $display("FAIL mid_rst_out: got req=%b valid=%b instr=%h want 0 0 %h", imem.req, fetch_valid, instr_if, NOP); end
    total++; if (pc_if !== 32'd0 || pc_plus4_if !== 32'd4) begin bad++; $display("FAIL mid_rst_pc: got %h/%h want 0/4", pc_if, pc_plus4_if); end
`ifdef FETCH_PERF_CNT_EN
    total++; if (fetch_wait_cycles !== 32'd0) begin bad++; $display("FAIL mid_rst_cnt: got %0d want 0", fetch_wait_cycles); end
`endif
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    total++; if (imem.req !== 1'b1 || imem.addr !== 32'd0) begin bad++; $display("FAIL mid_restart: got req=%b addr=%h want 1 0", imem.req, imem.addr); end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    cnt            = 0;
    lat            = 1;
    overlap        = 0;
    addr_q         = 32'd0;
    rst            = 1'b1;
    stall_if       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    imem.rvalid    = 1'b0;
    imem.rdata     = 32'd0;
    test_reset();
    test_first_fetch();
    test_sustained();
    test_stall();
    test_redirect();
    test_double_redirect();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
